// File: rtl/req_grnt_pkg.sv
// Shared types for the req/grnt initiator: FSM states and completion status codes.
package req_grnt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    WAIT    = 2'd2,
    BACKOFF = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_TIMEOUT = 2'b01,
    ERR_EARLY   = 2'b10
  } err_code_e;

endpackage

// File: rtl/req_grnt_sat_cnt.sv
// Event counter that sticks at all-ones instead of wrapping.
module req_grnt_sat_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/req_grnt_initiator.sv
// Requesting side of the req/grnt handshake: pulses req, waits for a grant edge
// inside a window, retries on timeout and reports status plus event counts.
module req_grnt_initiator
  import req_grnt_pkg::*;
#(
  parameter int MIN_WAIT  = 2,
  parameter int MAX_WAIT  = 4,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             req,
  input  logic             grnt,
  output logic             done,
  output logic [1:0]       err_code,
  output logic [1:0]       retries,
  output logic [CNT_W-1:0] grant_count,
  output logic [CNT_W-1:0] timeout_count,
  output logic [CNT_W-1:0] spurious_count
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] MIN_V = WCW'(MIN_WAIT);
  localparam logic [WCW-1:0] MAX_V = WCW'(MAX_WAIT);
  localparam logic [1:0]     MAX_R = 2'(MAX_RETRY);

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic [1:0]     retries_q, retries_d;
  err_code_e      err_q, err_d;
  logic           grnt_q, grnt_d;
  logic           busy_q, busy_d;
  logic           req_q, req_d;
  logic           done_q, done_d;
  logic           grnt_rise;
  logic           grant_inc, timeout_inc, spurious_inc;

  assign grnt_rise = grnt & ~grnt_q;

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    retries_d    = retries_q;
    err_d        = err_q;
    grnt_d       = grnt;
    done_d       = 1'b0;
    grant_inc    = 1'b0;
    timeout_inc  = 1'b0;
    spurious_inc = grnt_rise && (state_q != WAIT);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = REQ;
          retries_d = '0;
        end
      end
      REQ: begin
        state_d    = WAIT;
        wait_cnt_d = WCW'(1);
      end
      WAIT: begin
        if (grnt_rise && (wait_cnt_q >= MIN_V) && (wait_cnt_q <= MAX_V)) begin
          state_d   = IDLE;
          done_d    = 1'b1;
          err_d     = ERR_OK;
          grant_inc = 1'b1;
        end else if (grnt_rise) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = ERR_EARLY;
        end else if (wait_cnt_q == MAX_V) begin
          timeout_inc = 1'b1;
          if (retries_q < MAX_R) begin
            state_d = BACKOFF;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = ERR_TIMEOUT;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      BACKOFF: begin
        retries_d = retries_q + 2'd1;
        state_d   = REQ;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so decode them from the state being entered.
    req_d  = (state_d == REQ);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      retries_q  <= '0;
      err_q      <= ERR_OK;
      grnt_q     <= 1'b0;
      busy_q     <= 1'b0;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retries_q  <= retries_d;
      err_q      <= err_d;
      grnt_q     <= grnt_d;
      busy_q     <= busy_d;
      req_q      <= req_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign req      = req_q;
  assign done     = done_q;
  assign err_code = err_q;
  assign retries  = retries_q;

  req_grnt_sat_cnt #(.W(CNT_W)) u_grant_cnt (
    .clk (clk),
    .rst (rst),
    .inc (grant_inc),
    .cnt (grant_count)
  );

  req_grnt_sat_cnt #(.W(CNT_W)) u_timeout_cnt (
    .clk (clk),
    .rst (rst),
    .inc (timeout_inc),
    .cnt (timeout_count)
  );

  req_grnt_sat_cnt #(.W(CNT_W)) u_spurious_cnt (
    .clk (clk),
    .rst (rst),
    .inc (spurious_inc),
    .cnt (spurious_count)
  );

endmodule

// File: tb/tb_req_grnt_initiator.sv
// Directed bench for req_grnt_initiator: each applyStimulus call is one clock cycle,
// and outputs observed right after it belong to that same cycle.
module tb_req_grnt_initiator;

  logic       clk;
  logic       rst;
  logic       start;
  logic       grnt;
  logic       busy;
  logic       req;
  logic       done;
  logic [1:0] err_code;
  logic [1:0] retries;
  logic [7:0] grant_count;
  logic [7:0] timeout_count;
  logic [7:0] spurious_count;

  int total;
  int bad;

  req_grnt_initiator dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .req            (req),
    .grnt           (grnt),
    .done           (done),
    .err_code       (err_code),
    .retries        (retries),
    .grant_count    (grant_count),
    .timeout_count  (timeout_count),
    .spurious_count (spurious_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the next falling edge and drive this cycle's inputs there.
  task automatic applyStimulus(input logic s, input logic g);
    @(negedge clk);
    start = s;
    grnt  = g;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  initial begin
    int n_req;
    int n_done;
    int req_at[3];
    logic bo_busy;
    logic bo_req;
    logic prev_req;
    int back_to_back;

    total = 0;
    bad   = 0;
    rst   = 1'b1;
    start = 1'b0;
    grnt  = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_req", 32'(req), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_err", 32'(err_code), 0);
    checkOutput("rst_retries", 32'(retries), 0);
    checkOutput("rst_counts", {8'd0, grant_count, timeout_count, spurious_count}, 0);
    rst = 1'b0;

    // Grant rising at wait_cnt=3
    $display("[TB] grant at wait_cnt=3");
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    checkOutput("t1_req_pulse", 32'(req), 1);
    checkOutput("t1_busy", 32'(busy), 1);
    applyStimulus(0, 0);
    checkOutput("t1_req_single", 32'(req), 0);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    checkOutput("t1_no_early_done", 32'(done), 0);
    applyStimulus(0, 0);
    checkOutput("t1_done", 32'(done), 1);
    checkOutput("t1_err", 32'(err_code), 0);
    checkOutput("t1_busy_low", 32'(busy), 0);
    checkOutput("t1_grant_count", 32'(grant_count), 1);
    checkOutput("t1_retries", 32'(retries), 0);
    applyStimulus(0, 0);
    checkOutput("t1_done_pulse", 32'(done), 0);

    // No grant at all: three attempts, then a TIMEOUT completion
    $display("[TB] timeout with retries");
    applyStimulus(1, 0);
    n_req = 0;
    back_to_back = 0;
    prev_req = 1'b0;
    bo_busy = 1'b0;
    bo_req = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      applyStimulus(0, 0);
      if (req) begin
        if (n_req < 3) req_at[n_req] = k;
        n_req++;
        if (prev_req) back_to_back++;
      end
      prev_req = req;
      if (k == 6) begin
        bo_busy = busy;
        bo_req  = req;
      end
      if (k < 18 && done) checkOutput("t2_premature_done", 32'(k), 18);
    end
    checkOutput("t2_req_count", 32'(n_req), 3);
    checkOutput("t2_req0_at", 32'(req_at[0]), 1);
    checkOutput("t2_req1_at", 32'(req_at[1]), 7);
    checkOutput("t2_req2_at", 32'(req_at[2]), 13);
    checkOutput("t2_req_back_to_back", 32'(back_to_back), 0);
    checkOutput("t2_backoff_busy", 32'(bo_busy), 1);
    checkOutput("t2_backoff_req", 32'(bo_req), 0);
    checkOutput("t2_done", 32'(done), 1);
    checkOutput("t2_err", 32'(err_code), 1);
    checkOutput("t2_timeout_count", 32'(timeout_count), 3);
    checkOutput("t2_retries", 32'(retries), 2);

    // Early grant at wait_cnt=1
    $display("[TB] early grant");
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    checkOutput("t3_done", 32'(done), 1);
    checkOutput("t3_err", 32'(err_code), 2);
    checkOutput("t3_busy", 32'(busy), 0);
    checkOutput("t3_retries", 32'(retries), 0);
    checkOutput("t3_grant_count", 32'(grant_count), 1);

    // grnt held high across a new start, then a fresh edge at wait_cnt=4
    $display("[TB] held grant then edge at wait_cnt=4");
    applyStimulus(1, 1);
    checkOutput("t3_no_retry_req", 32'(req), 0);
    checkOutput("t3_no_retry_busy", 32'(busy), 0);
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    checkOutput("t4_done", 32'(done), 1);
    checkOutput("t4_err", 32'(err_code), 0);
    checkOutput("t4_grant_count", 32'(grant_count), 2);
    checkOutput("t4_spurious", 32'(spurious_count), 0);

    // Grant edge while idle
    $display("[TB] spurious grant in idle");
    applyStimulus(0, 0);
    applyStimulus(0, 1);
    applyStimulus(0, 0);
    checkOutput("t5_spurious", 32'(spurious_count), 1);
    checkOutput("t5_busy", 32'(busy), 0);
    checkOutput("t5_done", 32'(done), 0);

    // start held while busy must not spawn another request
    $display("[TB] start while busy");
    applyStimulus(1, 0);
    applyStimulus(1, 0);
    checkOutput("t6_req", 32'(req), 1);
    applyStimulus(1, 0);
    checkOutput("t6_req_ignored", 32'(req), 0);
    checkOutput("t6_busy", 32'(busy), 1);
    applyStimulus(1, 1);
    applyStimulus(0, 0);
    checkOutput("t6_done", 32'(done), 1);
    checkOutput("t6_err", 32'(err_code), 0);
    checkOutput("t6_grant_count", 32'(grant_count), 3);
    applyStimulus(0, 0);
    checkOutput("t6_idle_busy", 32'(busy), 0);
    checkOutput("t6_idle_req", 32'(req), 0);

    // Reset in the middle of WAIT
    $display("[TB] reset during wait");
    applyStimulus(1, 0);
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    checkOutput("t7_in_wait", 32'(busy), 1);
    rst = 1'b1;
    applyStimulus(0, 0);
    rst = 1'b0;
    checkOutput("t7_busy", 32'(busy), 0);
    checkOutput("t7_req", 32'(req), 0);
    checkOutput("t7_done", 32'(done), 0);
    checkOutput("t7_err", 32'(err_code), 0);
    checkOutput("t7_counts", {8'd0, grant_count, timeout_count, spurious_count}, 0);
    applyStimulus(0, 0);
    checkOutput("t7_stays_idle", 32'(busy), 0);

    // 260 back-to-back successes, each new start issued in the done cycle
    $display("[TB] grant counter saturation");
    n_req  = 0;
    n_done = 0;
    applyStimulus(1, 0);
    for (int i = 0; i < 260; i++) begin
      applyStimulus(0, 0);
      if (req) n_req++;
      applyStimulus(0, 0);
      applyStimulus(0, 1);
      applyStimulus((i < 259) ? 1'b1 : 1'b0, 0);
      if (done && err_code == 2'b00) n_done++;
    end
    applyStimulus(0, 0);
    checkOutput("t8_req_count", 32'(n_req), 260);
    checkOutput("t8_done_count", 32'(n_done), 260);
    checkOutput("t8_grant_sat", 32'(grant_count), 255);
    checkOutput("t8_timeouts", 32'(timeout_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
